// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter that feeds bytes to a UART transmitter and supervises its busy/done handshake.
// Optional build macro TX_ARB_LOCK_EN adds per-requester lock inputs that keep the grant with one requester.
module uart_tx_arb #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
`ifdef TX_ARB_LOCK_EN
    input  logic       req0_lock,
    input  logic       req1_lock,
`endif
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] tx_din,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       grant_id,
    output logic       arb_busy,
    output logic       err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
    logic             rr_prio;     // requester that wins the next tie
    logic             elig0, elig1;
    logic             accept, winner, timeout_hit;

`ifdef TX_ARB_LOCK_EN
    logic lock_hold;

    // While a lock is held only the current owner may be granted, even if the other side waits.
    assign elig0 = req0_valid && (!lock_hold || !grant_id);
    assign elig1 = req1_valid && (!lock_hold ||  grant_id);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lock_hold <= 1'b0;
        else if (state == WAIT_DONE && tx_done)
            lock_hold <= grant_id ? req1_lock : req0_lock;
        else if (timeout_hit)
            lock_hold <= 1'b0;
    end
`else
    assign elig0 = req0_valid;
    assign elig1 = req1_valid;
`endif

    assign accept      = (state == IDLE) && (elig0 || elig1);
    assign winner      = (elig0 && elig1) ? rr_prio : elig1;
    assign timeout_hit = (state == WAIT_BUSY) && !tx_busy && (to_cnt == CNT_LAST);

    // Ready is combinational from state, so it is also gated by reset to stay low while reset is held.
    assign req0_ready  = accept && !winner && !reset;
    assign req1_ready  = accept &&  winner && !reset;
    assign tx_start    = (state == LAUNCH);
    assign arb_busy    = (state != IDLE);
    assign err_timeout = timeout_hit;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = LAUNCH;
            end
            LAUNCH: begin
                state_nxt  = WAIT_BUSY;
                to_cnt_nxt = '0;
            end
            WAIT_BUSY: begin
                if (tx_busy)
                    state_nxt = WAIT_DONE;
                else if (timeout_hit)
                    state_nxt = IDLE;
                else
                    to_cnt_nxt = to_cnt + CNT_W'(1);
            end
            WAIT_DONE: begin
                if (tx_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            to_cnt   <= '0;
            tx_din   <= 8'h00;
            grant_id <= 1'b0;
            rr_prio  <= 1'b0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
            // tx_din only changes on an accept, so it stays stable for the whole frame.
            if (accept) begin
                tx_din   <= winner ? req1_data : req0_data;
                grant_id <= winner;
                rr_prio  <= ~winner;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed stimulus pushes expected grants, a monitor checks each tx_start.
// The lock scenario is compiled only when TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       tx_start;
    logic [7:0] tx_din;
    logic       tx_busy, tx_done;
    logic       grant_id, arb_busy, err_timeout;
`ifdef TX_ARB_LOCK_EN
    logic       req0_lock, req1_lock;
`endif

    logic xm_busy = 1'b0, xm_done = 1'b0;
    logic man_busy, man_done;
    assign tx_busy = xm_busy | man_busy;
    assign tx_done = xm_done | man_done;

    uart_tx_arb #(.TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
`ifdef TX_ARB_LOCK_EN
        .req0_lock  (req0_lock),
        .req1_lock  (req1_lock),
`endif
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .tx_start   (tx_start),
        .tx_din     (tx_din),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .grant_id   (grant_id),
        .arb_busy   (arb_busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } xfer_t;

    xfer_t      sb[$];
    xfer_t      mon_exp;
    bit         xmit_en = 1'b0;
    bit         frame_active = 1'b0;
    logic [7:0] last_din;
    int         start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares each launched transfer against the scoreboard and checks din stability at done.
    always @(negedge clk) begin
        if (reset) begin
            frame_active = 1'b0;
        end else begin
            if (req0_ready || req1_ready)
                check("ready_onehot", 32'(req0_ready & req1_ready), 0);
            if (tx_start) begin
                start_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    mon_exp = sb.pop_front();
                    check("grant_id", 32'(grant_id), 32'(mon_exp.id));
                    check("tx_din", 32'(tx_din), 32'(mon_exp.data));
                end
                frame_active = 1'b1;
                last_din     = tx_din;
            end
            if (err_timeout)
                frame_active = 1'b0;
            if (tx_done && frame_active) begin
                check("din_held", 32'(tx_din), 32'(last_din));
                frame_active = 1'b0;
            end
        end
    end

    // Transmitter model: busy one cycle after start, done pulse three cycles later.
    always begin
        @(negedge clk);
        if (tx_start && xmit_en && !reset) begin
            @(posedge clk); #1 xm_busy = 1'b1;
            repeat (3) @(posedge clk);
            #1 begin xm_busy = 1'b0; xm_done = 1'b1; end
            @(posedge clk); #1 xm_done = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        @(negedge clk);
        while (arb_busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(arb_busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        man_busy = 1'b0; man_done = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int k;
        reset = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h41;
        req1_valid = 1'b0; req1_data = 8'h00;
        man_busy = 1'b0; man_done = 1'b0;
`ifdef TX_ARB_LOCK_EN
        req0_lock = 1'b0; req1_lock = 1'b0;
`endif
        xmit_en = 1'b1;

        // Reset values with a request pending.
        @(negedge clk);
        check("rst_req0_ready", 32'(req0_ready), 0);
        check("rst_arb_busy", 32'(arb_busy), 0);
        check("rst_tx_din", 32'(tx_din), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_err", 32'(err_timeout), 0);

        // Single byte 8'h41 from req0.
        sb.push_back('{id: 1'b0, data: 8'h41});
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t1_req0_ready", 32'(req0_ready), 1);
        check("t1_req1_ready", 32'(req1_ready), 0);
        tick();
        @(negedge clk);
        check("t1_start_latency", 32'(tx_start), 1);
        check("t1_ready_low_busy", 32'(req0_ready), 0);
        tick();
        req0_valid = 1'b0;
        wait_idle("t1_idle");

        // Both requesters continuously valid: grants 0,1,0,1.
        do_reset();
        xmit_en = 1'b1;
        sb.push_back('{id: 1'b0, data: 8'hAA});
        sb.push_back('{id: 1'b1, data: 8'h55});
        sb.push_back('{id: 1'b0, data: 8'hAA});
        sb.push_back('{id: 1'b1, data: 8'h55});
        req0_data = 8'hAA; req1_data = 8'h55;
        req0_valid = 1'b1; req1_valid = 1'b1;
        g = 0; k = 0;
        while (g < 4 && k < 100) begin
            @(negedge clk);
            k++;
            if (req0_ready || req1_ready) g++;
            if (g == 4) begin
                tick();
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
        end
        check("t2_grants", 32'(g), 4);
        wait_idle("t2_idle");
        check("t2_sb_empty", 32'(sb.size()), 0);

        // Lone req1 against a pointer favouring req0, then tx_busy never rises.
        xmit_en = 1'b0;
        sb.push_back('{id: 1'b1, data: 8'h3C});
        tick();
        req1_data = 8'h3C; req1_valid = 1'b1;
        @(negedge clk);
        check("t3_req1_ready", 32'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!err_timeout && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("t3_err_seen", 32'(err_timeout), 1);
        check("t3_err_delay", 32'(cyc - start_cyc), 16);
        @(negedge clk);
        check("t3_err_one_cycle", 32'(err_timeout), 0);
        check("t3_arb_idle", 32'(arb_busy), 0);

        // Reset during WAIT_DONE after a req0 grant, then a tie must go to req0.
        sb.push_back('{id: 1'b0, data: 8'h77});
        tick();
        req0_data = 8'h77; req0_valid = 1'b1;
        @(negedge clk);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        tick();
        man_busy = 1'b1;
        tick();
        @(negedge clk);
        check("t4_in_frame", 32'(arb_busy), 1);
        #2;
        reset = 1'b1;
        req0_data = 8'h12; req1_data = 8'h34;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("t4_rst_tx_din", 32'(tx_din), 0);
        check("t4_rst_grant_id", 32'(grant_id), 0);
        check("t4_rst_arb_busy", 32'(arb_busy), 0);
        check("t4_rst_tx_start", 32'(tx_start), 0);
        check("t4_rst_ready0", 32'(req0_ready), 0);
        check("t4_rst_ready1", 32'(req1_ready), 0);
        check("t4_rst_err", 32'(err_timeout), 0);
        man_busy = 1'b0;
        tick();
        sb.push_back('{id: 1'b0, data: 8'h12});
        xmit_en = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        check("t4_tie_ready0", 32'(req0_ready), 1);
        check("t4_tie_ready1", 32'(req1_ready), 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle("t4_idle");

        // Stray tx_done/tx_busy in IDLE must be ignored.
        xmit_en = 1'b0;
        tick();
        man_done = 1'b1; man_busy = 1'b1;
        @(negedge clk);
        check("t5_ready0", 32'(req0_ready), 0);
        check("t5_ready1", 32'(req1_ready), 0);
        check("t5_arb_busy_a", 32'(arb_busy), 0);
        tick();
        man_done = 1'b0; man_busy = 1'b0;
        @(negedge clk);
        check("t5_arb_busy_b", 32'(arb_busy), 0);
        check("t5_tx_start", 32'(tx_start), 0);

`ifdef TX_ARB_LOCK_EN
        // req1 holds its lock for three bytes while req0 waits.
        do_reset();
        xmit_en = 1'b1;
        sb.push_back('{id: 1'b1, data: 8'h62});
        sb.push_back('{id: 1'b1, data: 8'h62});
        sb.push_back('{id: 1'b1, data: 8'h62});
        sb.push_back('{id: 1'b0, data: 8'hA0});
        req0_data = 8'hA0;
        req1_data = 8'h62; req1_lock = 1'b1; req1_valid = 1'b1;
        begin
            int g0 = 0;
            int g1 = 0;
            k = 0;
            while (g0 == 0 && k < 200) begin
                @(negedge clk);
                k++;
                if (req1_ready) g1++;
                if (req0_ready) g0++;
                tick();
                if (g1 >= 1) req0_valid = 1'b1;
                if (g1 == 3) begin req1_valid = 1'b0; req1_lock = 1'b0; end
                if (g0 == 1) req0_valid = 1'b0;
            end
            check("t6_req1_grants", 32'(g1), 3);
            check("t6_req0_grant", 32'(g0), 1);
        end
        wait_idle("t6_idle");
`endif

        check("final_sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, meaning clock cycles allowed from tx_start until tx_busy is seen high.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester has a byte to send.
REQ-005 SHALL have ports req0_data / req1_data  input  8  byte offered by the requester.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  one-cycle accept strobe; the byte is taken on this cycle.
REQ-007 SHALL have port tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-008 SHALL have port tx_din  output  8  byte to the transmitter, registered.
REQ-009 SHALL have ports tx_busy / tx_done  input  1  transmitter busy level and one-cycle done pulse.
REQ-010 SHALL have port grant_id  output  1  index of the requester owning the current or last transfer.
REQ-011 SHALL have port arb_busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port err_timeout  output  1  one-cycle pulse when the tx_busy wait times out.

Function
REQ-013 SHALL implement the states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE, with the state held in a 2-bit register.
REQ-014 SHALL, in IDLE with at least one valid request, select a winner, drive the winner's reqN_ready combinationally high for that cycle, latch the winner's data into tx_din and grant_id, and move to LAUNCH.
REQ-015 SHALL arbitrate round-robin: the requester not granted last wins ties; after reset req0 wins the first tie.
REQ-016 SHALL, with only one valid request, grant that requester regardless of the round-robin pointer.
REQ-017 SHALL update the round-robin pointer only on an accept.
REQ-018 SHALL assert tx_start for exactly the single cycle spent in LAUNCH, then enter WAIT_BUSY with the timeout counter at 0.
REQ-019 SHALL, in WAIT_BUSY, move to WAIT_DONE when tx_busy=1.
REQ-020 SHALL, in WAIT_BUSY, increment the timeout counter each cycle tx_busy=0; on reaching TIMEOUT_CYC-1 it SHALL pulse err_timeout and return to IDLE.
REQ-021 SHALL use a counter of width $clog2(TIMEOUT_CYC)+1 for the timeout, and that counter SHALL NOT wrap.
REQ-022 SHALL, in WAIT_DONE, return to IDLE on tx_done=1; IDLE may accept a new byte in the cycle immediately after.
REQ-023 SHALL hold tx_din stable from the accept until tx_done, because the transmitter samples din throughout the frame.
REQ-024 SHALL ignore tx_done and tx_busy in IDLE and LAUNCH.
REQ-025 SHALL give a minimum latency of 2 cycles from accept to tx_start (accept edge, then LAUNCH).
REQ-026 SHALL keep both reqN_ready signals low in every state except IDLE, and never drive both high in the same cycle.

Reset
REQ-027 SHALL, on reset (including mid-frame), force state=IDLE, tx_start=0, tx_din=8'h00, grant_id=0, the pointer to favour req0, the timeout counter=0 and err_timeout=0.
REQ-028 SHALL drive reqN_ready=0 and arb_busy=0 while reset is high.

Configuration
REQ-029 SHALL, when TX_ARB_LOCK_EN is defined, add inputs req0_lock and req1_lock (1 bit each).
REQ-030 SHALL, with TX_ARB_LOCK_EN defined, restrict the next IDLE arbitration to the granted requester if its lock was high at its tx_done, waiting for it even if the other requester is valid; the restriction SHALL release at a tx_done with lock low, or on a timeout.
REQ-031 SHALL, when TX_ARB_LOCK_EN is undefined, omit the lock ports and use pure round-robin.

Verification
REQ-032 SHALL cover: after reset, req0_valid=1 with data 8'h41 -> req0_ready pulse, tx_start 2 cycles later, tx_din=8'h41 held until tx_done.
REQ-033 SHALL cover: both valid continuously with data 8'hAA and 8'h55 -> grants in the order 0,1,0,1; tx_din alternates AA,55.
REQ-034 SHALL cover: tx_busy held 0 after tx_start -> err_timeout pulse exactly 16 cycles after LAUNCH, then return to IDLE and arb_busy=0.
REQ-035 SHALL cover: reset asserted during WAIT_DONE -> all outputs at reset values immediately; next grant goes to req0 on a tie.
REQ-036 SHALL cover: with TX_ARB_LOCK_EN, req1_lock=1 for 3 bytes while req0 is valid -> three consecutive req1 grants, then req0.
REQ-037 SHALL cover: a tx_done pulse injected in IDLE -> no state change and no ready pulse.
